uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit byte sink (the TX FIFO write side) between NumReq independent byte-stream requesters, such as the CPU console, a trace/log engine and a debug monitor.
- Uses round-robin arbitration at message granularity. A grant is held until a line terminator, a burst limit or an idle timeout, so lines from different sources never interleave.
- Can prefix each granted message with a one-byte source tag.
- Sits between the requesters and the UART TX FIFO write port.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        PASS = 2'd2
    } arb_state_t;

    localparam logic [7:0] UartNewline = 8'h0A;
    localparam logic [7:0] UartTagBase = 8'h30;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, with wrap.
module rr_arbiter #(
    parameter int N    = 3,
    parameter int IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    logic [IdxW-1:0] cand;

    // Scan offsets from the far end downward so the nearest offset to ptr_i wins last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = IdxW'((int'(ptr_i) + off) % N);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin sharing of the UART TX FIFO write port.
// Handshake: a byte moves when valid and ready are both high at a clk_i edge;
// a source must hold its byte stable while valid is high and ready is low.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         NumReq      = 3,
    parameter int         MaxBurst    = 64,
    parameter int         IdleTimeout = 255,
    parameter logic [7:0] Newline     = UartNewline,
    parameter logic       TagEnable   = 1'b1,
    parameter logic [7:0] TagBase     = UartTagBase,
    localparam int        GrantW      = idx_width(NumReq)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumReq-1:0]   req_valid_i,
    input  logic [8*NumReq-1:0] req_data_i,
    output logic [NumReq-1:0]   req_ready_o,
    output logic                tx_valid_o,
    output logic [7:0]          tx_data_o,
    input  logic                tx_ready_i,
    output logic [GrantW-1:0]   grant_o,
    output logic                busy_o
);

    localparam int BurstW = $clog2(MaxBurst + 1);
    localparam int IdleW  = $clog2(IdleTimeout + 1);
    localparam logic [BurstW-1:0] BurstLimit = BurstW'(MaxBurst);
    localparam logic [IdleW-1:0]  IdleLast   = IdleW'(IdleTimeout - 1);
    localparam logic [IdleW-1:0]  IdleMax    = {IdleW{1'b1}};
    localparam logic [GrantW-1:0] LastIdx    = GrantW'(NumReq - 1);

    arb_state_t          state_q, state_d;
    logic [GrantW-1:0]   grant_q, grant_d;
    logic [GrantW-1:0]   ptr_q, ptr_d;
    logic [NumReq-1:0]   gnt_oh_q, gnt_oh_d;
    logic [BurstW-1:0]   burst_q, burst_d;
    logic [IdleW-1:0]    idle_q, idle_d;

    logic [NumReq-1:0]   arb_gnt;
    logic [GrantW-1:0]   arb_idx;
    logic                arb_any;
    logic                sel_valid;
    logic [7:0]          sel_data;
    logic [BurstW-1:0]   burst_inc;
    logic                rel;

    rr_arbiter #(
        .N    (NumReq),
        .IdxW (GrantW)
    ) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .any_o (arb_any)
    );

    // Select the granted requester's byte and valid; non-granted lanes never reach tx_*.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt_oh_q[k]) sel_data = req_data_i[8*k +: 8];
        end
        sel_valid = |(req_valid_i & gnt_oh_q);
    end

    // Next-state, counters and output decode for the IDLE/TAG/PASS message FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        gnt_oh_d    = gnt_oh_q;
        burst_d     = burst_q;
        idle_d      = idle_q;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        req_ready_o = '0;
        busy_o      = 1'b0;
        rel         = 1'b0;
        burst_inc   = burst_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d  = arb_idx;
                    gnt_oh_d = arb_gnt;
                    burst_d  = '0;
                    idle_d   = '0;
                    state_d  = TagEnable ? TAG : PASS;
                end
            end
            TAG: begin
                busy_o     = 1'b1;
                tx_valid_o = 1'b1;
                tx_data_o  = TagBase + 8'(grant_q);
                if (tx_ready_i) state_d = PASS;
            end
            PASS: begin
                busy_o      = 1'b1;
                tx_valid_o  = sel_valid;
                tx_data_o   = sel_valid ? sel_data : 8'h00;
                req_ready_o = gnt_oh_q & {NumReq{tx_ready_i}};
                if (sel_valid && tx_ready_i) begin
                    burst_d = burst_inc;
                    idle_d  = '0;
                    // Newline and burst limit on the same byte still give one release.
                    if ((sel_data == Newline) || (burst_inc == BurstLimit)) rel = 1'b1;
                end else if (!sel_valid) begin
                    if (idle_q == IdleLast) rel = 1'b1;
                    else if (idle_q != IdleMax) idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Release always passes through IDLE, which guarantees a bubble between grants.
        if (rel) begin
            state_d = IDLE;
            ptr_d   = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
        end
    end

    assign grant_o = grant_q;

    // State register with synchronous reset; reset abandons any message in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            gnt_oh_q <= '0;
            burst_q  <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            gnt_oh_q <= gnt_oh_d;
            burst_q  <= burst_d;
            idle_q   <= idle_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with three requesters, burst limit 4 and idle timeout 8.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int MAX_BURST = 4;
    localparam int IDLE_TO   = 8;
    localparam int TAG_BASE  = 'h30;
    localparam logic [7:0] NEWLINE = 8'h0A;

    logic        clk_i;
    logic        rst_i;
    logic [2:0]  req_valid_i;
    logic [23:0] req_data_i;
    logic [2:0]  req_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic [1:0]  grant_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rst;
        logic [2:0]  v;
        logic [23:0] d;
        logic        rdy;
        logic        tv;
        logic [7:0]  td;
        logic [2:0]  rr;
        logic        busy;
        logic [1:0]  g;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] src_q[3][$];
    int         start_at[3];
    logic [7:0] exp_q[$];

    uart_tx_arbiter #(
        .NumReq      (NUM_REQ),
        .MaxBurst    (MAX_BURST),
        .IdleTimeout (IDLE_TO),
        .Newline     (8'h0A),
        .TagEnable   (1'b1),
        .TagBase     (8'h30)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .tx_valid_o  (tx_valid_o),
        .tx_data_o   (tx_data_o),
        .tx_ready_i  (tx_ready_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o)
    );

    // Clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: condition not met", name);
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] v, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [7:0] d2, input logic rdy,
                                input logic tv, input logic [7:0] td, input logic [2:0] rr,
                                input logic busy, input logic [1:0] g);
        vec_t r;
        r.rst = rst; r.v = v; r.d = {d2, d1, d0}; r.rdy = rdy;
        r.tv = tv; r.td = td; r.rr = rr; r.busy = busy; r.g = g;
        return r;
    endfunction

    // Drive one cycle of inputs, compare outputs mid-cycle, advance past the next edge.
    task automatic apply(input vec_t r, input string name);
        rst_i       = r.rst;
        req_valid_i = r.v;
        req_data_i  = r.d;
        tx_ready_i  = r.rdy;
        @(negedge clk_i);
        chk({name, ".tx_valid"},  32'(tx_valid_o),  32'(r.tv));
        chk({name, ".tx_data"},   32'(tx_data_o),   32'(r.td));
        chk({name, ".req_ready"}, 32'(req_ready_o), 32'(r.rr));
        chk({name, ".busy"},      32'(busy_o),      32'(r.busy));
        chk({name, ".grant"},     32'(grant_o),     32'(r.g));
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        tx_ready_i  = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    // Reference: grants visit non-empty sources round-robin; each grant emits a tag
    // then bytes until a newline, MAX_BURST bytes, or the source runs dry.
    task automatic build_expect();
        logic [7:0] m[3][$];
        int ptr;
        int g;
        int n;
        logic [7:0] b;
        ptr = 0;
        for (int k = 0; k < 3; k++) m[k] = src_q[k];
        exp_q.delete();
        while (m[0].size() + m[1].size() + m[2].size() > 0) begin
            g = -1;
            for (int i = 0; i < 3; i++) begin
                if (g < 0 && m[(ptr + i) % 3].size() > 0) g = (ptr + i) % 3;
            end
            exp_q.push_back(8'(TAG_BASE + g));
            n = 0;
            do begin
                b = m[g].pop_front();
                exp_q.push_back(b);
                n++;
            end while (b != NEWLINE && n < MAX_BURST && m[g].size() > 0);
            ptr = (g + 1) % 3;
        end
    endtask

    // Sources present queued bytes continuously; every TX handshake is scored against exp_q.
    task automatic run_streams(input int budget, input int rdy_pct, input string name);
        bit done;
        done = 1'b0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            for (int k = 0; k < 3; k++) begin
                if (cyc >= start_at[k] && src_q[k].size() > 0) begin
                    req_valid_i[k]        = 1'b1;
                    req_data_i[8*k +: 8]  = src_q[k][0];
                end else begin
                    req_valid_i[k]        = 1'b0;
                    req_data_i[8*k +: 8]  = 8'h00;
                end
            end
            tx_ready_i = ($urandom_range(99) < rdy_pct);
            @(negedge clk_i);
            if (tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0) flag({name, ".extra_byte"});
                else chk({name, ".byte"}, 32'(tx_data_o), 32'(exp_q.pop_front()));
            end
            for (int k = 0; k < 3; k++) begin
                if (req_valid_i[k] && req_ready_o[k]) begin
                    chk({name, ".ack_path"}, 32'({tx_valid_o, tx_data_o}), 32'({1'b1, src_q[k][0]}));
                    void'(src_q[k].pop_front());
                end
            end
            if (exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                src_q[2].size() == 0 && !busy_o) done = 1'b1;
            @(posedge clk_i);
            #1;
        end
        if (!done) flag({name, ".cycle_budget"});
        chk({name, ".left_over"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = '0;
        req_data_i  = '0;
        tx_ready_i  = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Vector table: single source "AB\n", then two sources contending after a reset.
        tbl.push_back(mk(0, 3'b001, 8'h41, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0));
        tbl.push_back(mk(0, 3'b001, 8'h41, 8'h00, 8'h00, 1, 1, 8'h30, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 8'h41, 8'h00, 8'h00, 1, 1, 8'h41, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b001, 8'h42, 8'h00, 8'h00, 1, 1, 8'h42, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b001, 8'h0A, 8'h00, 8'h00, 1, 1, 8'h0A, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0));
        tbl.push_back(mk(1, 3'b000, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0));
        tbl.push_back(mk(0, 3'b011, 8'h78, 8'h78, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0));
        tbl.push_back(mk(0, 3'b011, 8'h78, 8'h78, 8'h00, 1, 1, 8'h30, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b011, 8'h78, 8'h78, 8'h00, 1, 1, 8'h78, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b011, 8'h0A, 8'h78, 8'h00, 1, 1, 8'h0A, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b011, 8'h79, 8'h78, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0));
        tbl.push_back(mk(0, 3'b011, 8'h79, 8'h78, 8'h00, 1, 1, 8'h31, 3'b000, 1, 1));
        tbl.push_back(mk(0, 3'b011, 8'h79, 8'h78, 8'h00, 1, 1, 8'h78, 3'b010, 1, 1));
        tbl.push_back(mk(0, 3'b011, 8'h79, 8'h0A, 8'h00, 1, 1, 8'h0A, 3'b010, 1, 1));
        tbl.push_back(mk(0, 3'b001, 8'h79, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 0, 1));
        tbl.push_back(mk(0, 3'b001, 8'h79, 8'h00, 8'h00, 1, 1, 8'h30, 3'b000, 1, 0));
        tbl.push_back(mk(0, 3'b001, 8'h79, 8'h00, 8'h00, 1, 1, 8'h79, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b001, 8'h0A, 8'h00, 8'h00, 1, 1, 8'h0A, 3'b001, 1, 0));
        tbl.push_back(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

        // Idle timeout: source 0 goes quiet after one byte; source 1 waits.
        do_reset();
        apply(mk(0, 3'b011, 8'h61, 8'h62, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0), "idle.arb");
        apply(mk(0, 3'b011, 8'h61, 8'h62, 8'h00, 1, 1, 8'h30, 3'b000, 1, 0), "idle.tag");
        apply(mk(0, 3'b011, 8'h61, 8'h62, 8'h00, 1, 1, 8'h61, 3'b001, 1, 0), "idle.byte");
        for (int i = 0; i < IDLE_TO; i++)
            apply(mk(0, 3'b010, 8'h00, 8'h62, 8'h00, 1, 0, 8'h00, 3'b001, 1, 0), $sformatf("idle.wait[%0d]", i));
        apply(mk(0, 3'b010, 8'h00, 8'h62, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0), "idle.released");
        apply(mk(0, 3'b010, 8'h00, 8'h62, 8'h00, 1, 1, 8'h31, 3'b000, 1, 1), "idle.next_tag");
        apply(mk(0, 3'b010, 8'h00, 8'h62, 8'h00, 1, 1, 8'h62, 3'b010, 1, 1), "idle.next_byte");

        // Back-pressure in TAG and PASS: outputs hold, no acks, no timeout.
        do_reset();
        apply(mk(0, 3'b010, 8'h00, 8'h71, 8'h00, 0, 0, 8'h00, 3'b000, 0, 0), "stall.arb");
        for (int i = 0; i < 10; i++)
            apply(mk(0, 3'b010, 8'h00, 8'h71, 8'h00, 0, 1, 8'h31, 3'b000, 1, 1), $sformatf("stall.tag[%0d]", i));
        apply(mk(0, 3'b010, 8'h00, 8'h71, 8'h00, 1, 1, 8'h31, 3'b000, 1, 1), "stall.tag_go");
        for (int i = 0; i < 20; i++)
            apply(mk(0, 3'b010, 8'h00, 8'h71, 8'h00, 0, 1, 8'h71, 3'b000, 1, 1), $sformatf("stall.pass[%0d]", i));
        apply(mk(0, 3'b010, 8'h00, 8'h71, 8'h00, 1, 1, 8'h71, 3'b010, 1, 1), "stall.byte");
        apply(mk(0, 3'b010, 8'h00, 8'h0A, 8'h00, 1, 1, 8'h0A, 3'b010, 1, 1), "stall.nl");
        apply(mk(0, 3'b000, 8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 0, 1), "stall.idle");

        // Reset mid-message on source 1 after the pointer has moved off 0.
        do_reset();
        apply(mk(0, 3'b001, 8'h6B, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0), "rst.m0");
        apply(mk(0, 3'b001, 8'h6B, 8'h00, 8'h00, 1, 1, 8'h30, 3'b000, 1, 0), "rst.m1");
        apply(mk(0, 3'b001, 8'h6B, 8'h00, 8'h00, 1, 1, 8'h6B, 3'b001, 1, 0), "rst.m2");
        apply(mk(0, 3'b001, 8'h0A, 8'h00, 8'h00, 1, 1, 8'h0A, 3'b001, 1, 0), "rst.m3");
        apply(mk(0, 3'b010, 8'h00, 8'h31, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0), "rst.m4");
        apply(mk(0, 3'b010, 8'h00, 8'h31, 8'h00, 1, 1, 8'h31, 3'b000, 1, 1), "rst.m5");
        apply(mk(0, 3'b010, 8'h00, 8'h31, 8'h00, 1, 1, 8'h31, 3'b010, 1, 1), "rst.m6");
        apply(mk(0, 3'b010, 8'h00, 8'h32, 8'h00, 1, 1, 8'h32, 3'b010, 1, 1), "rst.m7");
        apply(mk(1, 3'b010, 8'h00, 8'h33, 8'h00, 1, 1, 8'h33, 3'b010, 1, 1), "rst.m8");
        apply(mk(0, 3'b011, 8'h6B, 8'h33, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0), "rst.after");
        apply(mk(0, 3'b011, 8'h6B, 8'h33, 8'h00, 1, 1, 8'h30, 3'b000, 1, 0), "rst.regrant");

        // Burst limit: source 2 streams ten bytes, source 0 joins two cycles later.
        do_reset();
        for (int k = 0; k < 3; k++) src_q[k].delete();
        for (int i = 0; i < 10; i++) src_q[2].push_back(8'(8'h61 + i));
        src_q[0] = '{8'h7A, 8'h0A};
        start_at = '{2, 0, 0};
        exp_q = '{8'h32, 8'h61, 8'h62, 8'h63, 8'h64, 8'h30, 8'h7A, 8'h0A,
                  8'h32, 8'h65, 8'h66, 8'h67, 8'h68, 8'h32, 8'h69, 8'h6A};
        run_streams(400, 100, "burst");

        // Random streams with random back-pressure against the reference model.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int k = 0; k < 3; k++) begin
                int len;
                src_q[k].delete();
                len = $urandom_range(0, 10);
                for (int i = 0; i < len; i++)
                    src_q[k].push_back(($urandom_range(0, 5) == 0) ? NEWLINE : 8'($urandom_range(32, 126)));
            end
            start_at = '{0, 0, 0};
            build_expect();
            run_streams(3000, $urandom_range(30, 100), $sformatf("rand[%0d]", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
